// File: rtl/deserializer_16_if.sv
// Serial-in / parallel-out bus between the bit-stream source and deserializer_16.
// master is the source side (drives the bit stream), slave is the deserializer.
interface deserializer_16_if;
    logic        in;
    logic [15:0] data;
    logic        data_valid;
    logic        sof;
    logic        locked;
    logic        sync_err;

    modport master (output in, input data, data_valid, sof, locked, sync_err);
    modport slave  (input in, output data, data_valid, sof, locked, sync_err);
endinterface

// File: rtl/deserializer_16.sv
// Sync-word hunting deserializer: aligns an MSB-first bit stream on SYNC_WORD and
// emits FRAME_WORDS payload words per frame, verifying the trailing sync word.
module deserializer_16 #(
    parameter logic [15:0] SYNC_WORD   = 16'hF0A5,
    parameter int          FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    deserializer_16_if.slave bus
);
    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);

    // Only the 15 older bits are stored; the window always includes the live sample.
    logic [14:0] sr_q,       sr_d;
    logic [4:0]  fill_q,     fill_d;
    state_t      state_q,    state_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [15:0] data_q,     data_d;
    logic        data_valid_q, data_valid_d;
    logic        sof_q,      sof_d;
    logic        locked_q,   locked_d;
    logic        sync_err_q, sync_err_d;

    logic [15:0] window;
    logic        sync_hit;
    logic        word_done;

    assign window    = {sr_q, bus.in};
    assign sync_hit  = (window == SYNC_WORD);
    assign word_done = (bit_cnt_q == 4'd15);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q         <= '0;
            fill_q       <= '0;
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sof_q        <= sof_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sr_d       = window[14:0];
        fill_d     = (fill_q == 5'd16) ? fill_q : fill_q + 5'd1;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 4'd1;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                // 15 bits already held means this sample completes a full window.
                if (sync_hit && fill_q >= 5'd15) begin
                    state_d    = PAYLOAD;
                    word_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                if (word_done) begin
                    word_cnt_d = word_cnt_q + 8'd1;
                    if (word_cnt_q == LAST_WORD) state_d = CHECK;
                end
            end
            CHECK: begin
                if (word_done) begin
                    if (sync_hit) begin
                        state_d    = PAYLOAD;
                        word_cnt_d = '0;
                    end else begin
                        state_d    = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        data_d       = data_q;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        locked_d     = locked_q;
        sync_err_d   = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sync_hit && fill_q >= 5'd15) locked_d = 1'b1;
            end
            PAYLOAD: begin
                if (word_done) begin
                    data_d       = window;
                    data_valid_d = 1'b1;
                    sof_d        = (word_cnt_q == 8'd0);
                end
            end
            CHECK: begin
                if (word_done && !sync_hit) begin
                    sync_err_d = 1'b1;
                    locked_d   = 1'b0;
                end
            end
            default: locked_d = 1'b0;
        endcase
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.sof        = sof_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_deserializer_16.sv
// Randomized and directed bench for deserializer_16 against a frame-offset
// reference model that tracks position in the bit stream arithmetically.
module tb_deserializer_16;
    localparam logic [15:0] SYNC = 16'hF0A5;
    localparam int          F    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deserializer_16_if bus ();

    deserializer_16 #(.SYNC_WORD(SYNC), .FRAME_WORDS(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position is "bits since the last sync word ended".
    logic [15:0] m_win, m_data;
    int          m_fill, m_since;
    bit          m_locked, m_dv, m_sof, m_err;

    logic        stim[$];
    logic [15:0] got_data[$];
    logic [3:0]  got_flags, exp_flags;

    task automatic model_reset();
        m_win = '0; m_data = '0; m_fill = 0; m_since = 0;
        m_locked = 0; m_dv = 0; m_sof = 0; m_err = 0;
    endtask

    task automatic model_step(input logic b);
        int w;
        m_win = {m_win[14:0], b};
        m_dv = 0; m_sof = 0; m_err = 0;
        if (!m_locked) begin
            if (m_fill >= 15 && m_win == SYNC) begin
                m_locked = 1; m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since % 16 == 0) begin
                w = m_since / 16 - 1;
                if (w < F) begin
                    m_dv = 1; m_sof = (w == 0); m_data = m_win;
                end else if (m_win == SYNC) begin
                    m_since = 0;
                end else begin
                    m_err = 1; m_locked = 0;
                end
            end
        end
        if (m_fill < 16) m_fill++;
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int b = 15; b >= 0; b--) stim.push_back(w[b]);
    endtask

    // Drives one bit, lets the model see the same edge, then samples 1 ns later.
    task automatic drive_bit(input logic b);
        bus.in = b;
        @(posedge clk);
        model_step(b);
        #1;
        got_flags = {bus.data_valid, bus.sof, bus.locked, bus.sync_err};
        exp_flags = {m_dv, m_sof, m_locked, m_err};
        if (bus.data_valid === 1'b1) got_data.push_back(bus.data);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        stim.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({bus.data, bus.data_valid, bus.sof, bus.locked, bus.sync_err} !== 20'h0)
                $display("FAIL reset_hold: got data=%h flags=%b%b%b%b want all 0", bus.data,
                         bus.data_valid, bus.sof, bus.locked, bus.sync_err);
            else n_pass++;
        end
        rst = 1'b0;
        model_reset();
        push_word(SYNC);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            n_checks++;
            if (bus.locked !== (i == 15))
                $display("FAIL reset_first_lock bit %0d: locked=%b want %b", i + 1, bus.locked, i == 15);
            else n_pass++;
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        push_word(SYNC); push_word(16'h1234); push_word(16'h5678); push_word(16'h9ABC);
        push_word(16'hDEF0); push_word(SYNC); push_word(16'h0001);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            n_checks++;
            if (got_flags !== exp_flags || bus.data !== m_data)
                $display("FAIL nominal bit %0d: flags=%b data=%h want %b %h", i, got_flags, bus.data, exp_flags, m_data);
            else n_pass++;
            if (i >= 16) begin
                n_checks++;
                if (bus.locked !== 1'b1 || bus.sync_err !== 1'b0)
                    $display("FAIL nominal_lock bit %0d: locked=%b err=%b want 1 0", i, bus.locked, bus.sync_err);
                else n_pass++;
            end
        end
        n_checks++;
        if (got_data.size() != 5 || got_data[0] !== 16'h1234 || got_data[3] !== 16'hDEF0 || got_data[4] !== 16'h0001)
            $display("FAIL nominal_words: got %0d words, last=%h want 5 ending 0001",
                     got_data.size(), got_data.size() ? got_data[got_data.size()-1] : 16'hx);
        else n_pass++;
    endtask

    task automatic test_bad_trailer();
        int errs;
        errs = 0;
        apply_reset();
        push_word(SYNC);
        for (int w = 0; w < F; w++) push_word(16'($urandom));
        push_word(16'h0000);
        push_word(SYNC); push_word(16'h1111);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            if (bus.sync_err === 1'b1) errs++;
            n_checks++;
            if (got_flags !== exp_flags || bus.data !== m_data)
                $display("FAIL bad_trailer bit %0d: flags=%b data=%h want %b %h", i, got_flags, bus.data, exp_flags, m_data);
            else n_pass++;
            if (i == 16 * (F + 2) - 1) begin
                n_checks++;
                if ({bus.sync_err, bus.locked, bus.data_valid} !== 3'b100)
                    $display("FAIL bad_trailer_pulse: err/lock/dv=%b want 100", {bus.sync_err, bus.locked, bus.data_valid});
                else n_pass++;
            end
        end
        n_checks++;
        if (errs != 1 || bus.data !== 16'h1111 || bus.sof !== 1'b1 || bus.locked !== 1'b1)
            $display("FAIL bad_trailer_relock: errs=%0d data=%h sof=%b locked=%b want 1 1111 1 1",
                     errs, bus.data, bus.sof, bus.locked);
        else n_pass++;
    endtask

    task automatic test_misalign();
        apply_reset();
        stim = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        push_word(SYNC); push_word(16'hAAAA);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            n_checks++;
            if (got_flags !== exp_flags || bus.data !== m_data)
                $display("FAIL misalign bit %0d: flags=%b data=%h want %b %h", i, got_flags, bus.data, exp_flags, m_data);
            else n_pass++;
        end
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data !== 16'hAAAA || bus.sof !== 1'b1)
            $display("FAIL misalign_word: dv=%b data=%h sof=%b want 1 aaaa 1", bus.data_valid, bus.data, bus.sof);
        else n_pass++;
    endtask

    task automatic test_false_sync();
        int errs;
        errs = 0;
        apply_reset();
        push_word(SYNC); push_word(16'h00F0); push_word(16'hA5FF); push_word(SYNC);
        push_word(16'h1234); push_word(SYNC);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            if (bus.sync_err === 1'b1) errs++;
            n_checks++;
            if (got_flags !== exp_flags || bus.data !== m_data)
                $display("FAIL false_sync bit %0d: flags=%b data=%h want %b %h", i, got_flags, bus.data, exp_flags, m_data);
            else n_pass++;
        end
        n_checks++;
        if (got_data.size() != 4 || got_data[0] !== 16'h00F0 || got_data[1] !== 16'hA5FF ||
            got_data[2] !== SYNC || got_data[3] !== 16'h1234 || errs != 0 || bus.locked !== 1'b1)
            $display("FAIL false_sync_words: got %0d words errs=%0d locked=%b want 4 words 0 1",
                     got_data.size(), errs, bus.locked);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_word(SYNC); push_word(16'h1357); push_word(16'h2468);
        for (int b = 15; b >= 9; b--) stim.push_back(1'($urandom));
        foreach (stim[i]) drive_bit(stim[i]);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.data, bus.data_valid, bus.sof, bus.locked, bus.sync_err} !== 20'h0)
            $display("FAIL reset_mid_async: data=%h lock=%b want 0 0", bus.data, bus.locked);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            bus.in = 1'($urandom);
            @(posedge clk); #1;
            if (i == 12) rst = 1'b0;
            n_checks++;
            if (bus.data_valid !== 1'b0)
                $display("FAIL reset_mid_nodv cycle %0d: dv=%b want 0", i, bus.data_valid);
            else n_pass++;
        end
        apply_reset();
        push_word(SYNC); push_word(16'h1234); push_word(16'h5678); push_word(16'h9ABC);
        push_word(16'hDEF0); push_word(SYNC); push_word(16'h0001);
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            n_checks++;
            if (got_flags !== exp_flags || bus.data !== m_data)
                $display("FAIL reset_mid_frame bit %0d: flags=%b data=%h want %b %h", i, got_flags, bus.data, exp_flags, m_data);
            else n_pass++;
        end
        n_checks++;
        if (got_data.size() != 5 || got_data[1] !== 16'h5678 || got_data[4] !== 16'h0001)
            $display("FAIL reset_mid_words: got %0d words want 5", got_data.size());
        else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            repeat ($urandom_range(0, 20)) stim.push_back(1'($urandom));
            push_word(SYNC);
            for (int fr = 0; fr < 3; fr++) begin
                for (int w = 0; w < F; w++) push_word(16'($urandom));
                push_word(($urandom_range(0, 3) != 0) ? SYNC : 16'($urandom));
            end
            for (int w = 0; w < 3; w++) push_word(16'($urandom));
            foreach (stim[i]) begin
                drive_bit(stim[i]);
                n_checks++;
                if (got_flags !== exp_flags || bus.data !== m_data)
                    $display("FAIL random_%0d bit %0d: flags=%b data=%h want %b %h",
                             it, i, got_flags, bus.data, exp_flags, m_data);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.in = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_bad_trailer();
        test_misalign();
        test_false_sync();
        test_reset_mid();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule

// File: doc/deserializer_16.md
# deserializer_16

Receive-side stage placed directly downstream of the 16-bit MSB-first serializer. It consumes the one-bit-per-clock stream, hunts for a 16-bit sync word, and then delivers fixed-length frames of 16-bit payload words on a parallel bus. The sync word that trails each frame is checked, and lock is dropped when that check fails.

## Interface
- SYNC_WORD, 16'hF0A5, alignment pattern, MSB received first; must not be 16'h0000 or 16'hFFFF
- FRAME_WORDS, 4, payload words between consecutive sync words; legal range 1..255
- clk  input  1  single clock; all sampling is on the rising edge
- rst  input  1  reset, asynchronous and active-high; clears all state immediately
- in  input  1  serial bit stream, MSB first, one bit per clk
- data  output  16  last completed payload word; held between words
- data_valid  output  1  one-cycle pulse when data is updated
- sof  output  1  asserted together with data_valid for payload word 0 of a frame
- locked  output  1  high while the word alignment is established
- sync_err  output  1  one-cycle pulse when the trailing sync check fails

## Operation
- Shift register sr[15:0] is updated every clock as sr <= {sr[14:0], in}. "Window" means {sr[14:0], in}, the 16 most recent bits including the current sample.
- Fill counter (5 bits, saturating at 16) counts bits sampled since reset. HUNT ignores window matches until 15 bits are already held, so the 16th sampled bit is the earliest possible match.
- States:
  - HUNT. If window == SYNC_WORD and the fill condition is met: go to PAYLOAD, clear bit_cnt and word_cnt, set locked.
  - PAYLOAD. bit_cnt (4 bits) counts 0..15 and wraps. When bit_cnt == 15: data <= window, data_valid = 1, sof = (word_cnt == 0), word_cnt increments. When word_cnt == FRAME_WORDS-1 at that same edge, go to CHECK.
  - CHECK. bit_cnt counts 0..15. When bit_cnt == 15:
    - If window == SYNC_WORD: go to PAYLOAD and clear word_cnt; locked stays 1.
    - Otherwise: sync_err = 1, locked = 0, go to HUNT.
    - No data_valid is produced in CHECK in either case.
- While locked, a sync pattern inside a payload word, or straddling two payload words, is ordinary data. It does not cause realignment.
- After a sync error, hunting resumes on the next edge with the shift history kept. No refill wait applies.
- word_cnt is 8 bits wide. All counters wrap modulo their width; no arithmetic saturates except the fill counter.

## Timing
- Reset values: data = 0, data_valid = 0, sof = 0, locked = 0, sync_err = 0, sr = 0, fill = 0, state = HUNT.
- Let edge E0 be the edge that samples the last sync bit. locked = 1 in the cycle after E0.
- Payload word n has its bits sampled at edges E0+16n+1 .. E0+16n+16. data and data_valid are visible in the cycle after edge E0+16n+16. Latency is 1 clock from the last bit of the word.
- Trailing sync bits are sampled at edges E0+16F+1 .. E0+16F+16, where F = FRAME_WORDS. The sync_err pulse, or continuation into the next frame, takes effect after edge E0+16F+16.
- data_valid, sof and sync_err are never high for two consecutive cycles.
- Reset mid-word, asserted asynchronously: every output and all state go to their reset values at once. A partial word is discarded and no data_valid is issued.
- On the first edge after rst deasserts, in is sampled as bit 1 of the fill count.

## Test plan
- Reset check: assert rst, drive random in -> all outputs stay 0 and locked = 0. Deassert rst, then send 15 bits followed by a 16th bit that completes 16'hF0A5 -> lock occurs exactly at the 16th bit, not before.
- Nominal frame: send F0A5, 1234, 5678, 9ABC, DEF0, F0A5, 0001 -> four data_valid pulses 16 cycles apart carrying 1234/5678/9ABC/DEF0. sof is high only on the 1234 pulse, locked stays 1, a fifth pulse carries 0001 with sof = 1, and sync_err stays 0.
- Bad trailer: send F0A5, four payload words, then 0000 -> sync_err pulses once in the cycle after the 16th trailer bit, locked goes to 0, and data_valid stays 0. Then send F0A5 and 1111 -> relock, and data = 1111 with sof = 1.
- Misalignment: send 5 garbage bits (10110), then F0A5 and AAAA -> lock aligns to the sync boundary and data = AAAA.
- False sync inside payload: after lock, send payload words 00F0 and A5FF (a sync pattern straddles them) and F0A5 as the third word -> data values are delivered unchanged, with no realignment and no sync_err.
- Reset mid-operation: assert rst 7 bits into payload word 2 -> outputs clear immediately and no data_valid follows. After release, a fresh F0A5 plus frame behaves as in the nominal-frame test.
